// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5
  } state_e;

  // Frame start marker; only meaningful while idle.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Values reported on err_code_o.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/prog_loader_word_asm.sv
// prog_loader_word_asm: byte-lane counter and little-endian 32-bit word
// assembler. word_o presents the word including the byte being accepted this
// cycle, so it is complete in the same cycle word_valid_o strobes.
module prog_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // Next lane and word contents: clear wins, otherwise drop the byte into its lane.
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clr_i) begin
      lane_d = 2'd0;
      word_d = 32'd0;
    end else if (byte_valid_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d = lane_q + 2'd1;
    end else begin
      lane_d = lane_q;
    end
  end

  // Lane and partial-word registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_d;
  assign word_valid_o = byte_valid_i && !clr_i && (lane_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that receives a framed byte stream
// (A5, count lo, count hi, count*4 data bytes, checksum) and writes the words
// into instruction ROM over a rib master port while holding the core halted.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_gnt_i,
  output logic        halt_o,
  output logic        done_o,
  output logic        ok_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  sum_q, sum_d;
  logic        rx_ready_q, rx_ready_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        halt_q, halt_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        acc_s;
  logic [15:0] len_s;
  logic        asm_clr_s;
  logic        asm_vld_s;
  logic [31:0] asm_word_s;
  logic        asm_word_vld_s;

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_run_s;
`else
  logic        unused_tmo_cfg_s;
  assign unused_tmo_cfg_s = ^TIMEOUT_CYCLES;
`endif

  assign acc_s = rx_valid_i && rx_ready_q;
  assign len_s = {rx_data_i, count_q[7:0]};

  prog_loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr_s),
    .byte_valid_i (asm_vld_s),
    .byte_i       (rx_data_i),
    .word_o       (asm_word_s),
    .word_valid_o (asm_word_vld_s)
  );

  // Frame FSM: next state, frame bookkeeping and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    halt_d     = halt_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    code_d     = code_q;
    asm_clr_s  = 1'b0;
    asm_vld_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_s && (rx_data_i == HDR_BYTE)) begin
          state_d    = ST_LEN0;
          halt_d     = 1'b1;
          ok_d       = 1'b0;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
          sum_d      = 8'd0;
          word_idx_d = 16'd0;
          asm_clr_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (acc_s) begin
          count_d[7:0] = rx_data_i;
          state_d      = ST_LEN1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (acc_s) begin
          count_d = len_s;
          if (len_s == 16'd0) begin
            state_d = ST_CSUM;
          end else if ({16'd0, len_s} > MAX_WORDS) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (acc_s) begin
          sum_d     = sum_q + rx_data_i;
          asm_vld_s = 1'b1;
          if (asm_word_vld_s) begin
            state_d    = ST_WRITE;
            mem_data_d = asm_word_s;
            mem_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (mem_gnt_i) begin
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_q == (count_q - 16'd1)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CSUM: begin
        if (acc_s) begin
          if (rx_data_i == sum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
          done_d  = 1'b1;
          halt_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CSUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        halt_d  = 1'b0;
      end
    endcase

`ifdef PROG_LOADER_TIMEOUT_EN
    // Inter-byte watchdog: restarts on every accepted byte, frozen while idle or writing.
    tmo_run_s = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                (state_q == ST_DATA) || (state_q == ST_CSUM);
    if (acc_s) begin
      tmo_d = 32'd0;
    end else if (tmo_run_s && (tmo_q == (TIMEOUT_CYCLES - 32'd1))) begin
      tmo_d   = 32'd0;
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      done_d  = 1'b1;
      halt_d  = 1'b0;
    end else if (tmo_run_s) begin
      tmo_d = tmo_q + 32'd1;
    end else begin
      tmo_d = tmo_q;
    end
`endif

    // Bus request and byte ready follow the state being entered so both are registered.
    mem_req_d  = (state_d == ST_WRITE);
    rx_ready_d = (state_d != ST_WRITE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      sum_q      <= 8'd0;
      rx_ready_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      rx_ready_q <= rx_ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

`ifdef PROG_LOADER_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign rx_ready_o = rx_ready_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign halt_o     = halt_q;
  assign done_o     = done_q;
  assign ok_o       = ok_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader; fills instruction ROM over the rib bus from a byte stream (UART rx or bench driver).
- Holds the core halted while loading.
- Sits directly upstream of the SoC core/ROM: what is loaded here is what the core fetches.
- Sits between the byte source and a rib master port.

Parameters:
- BASE_ADDR, 32'h0000_0000, bus address of word 0 (ROM base).
- MAX_WORDS, 4096, largest accepted word count; larger counts are rejected.
- TIMEOUT_CYCLES, 50000, inter-byte timeout; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (asserted when rst==0, sampled on rising clk)
- rx_valid_i  input  1  byte available
- rx_data_i  input  8  byte value
- rx_ready_o  output  1  byte accepted when rx_valid_i && rx_ready_o
- mem_req_o  output  1  bus write request
- mem_we_o  output  1  write enable; equals mem_req_o
- mem_addr_o  output  32  write address
- mem_data_o  output  32  write data
- mem_gnt_i  input  1  bus grant; completes the write in the same cycle
- halt_o  output  1  core hold request
- done_o  output  1  one-cycle pulse at end of frame, pass or fail
- ok_o  output  1  sticky: last frame loaded and checksum matched
- err_o  output  1  sticky: last frame failed
- err_code_o  output  2  01 = length, 10 = checksum, 11 = timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and checksum cleared.
- Frame format: 0xA5; count low byte; count high byte; count×4 data bytes (little-endian words); 1 checksum byte.
- Checksum: sum of data bytes mod 256.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM.
- rx_ready_o = 1 in every state except WRITE.
- IDLE:
  - Bytes other than 0xA5 are discarded.
  - On 0xA5: go to LEN0, set halt_o next cycle, clear ok_o/err_o/err_code_o, clear sum and word_idx.
  - 0xA5 arriving in any other state is ordinary payload.
- LEN0: latch count[7:0]. LEN1: latch count[15:8].
  - count == 0 → CSUM (expected checksum 0x00).
  - count > MAX_WORDS → err_o=1, code 01, done_o pulse, halt_o=0, go to IDLE.
  - Otherwise → DATA.
- DATA:
  - Byte k (k = 0..3) goes into word[8k+7:8k]; sum += byte.
  - After the 4th byte → WRITE.
- WRITE:
  - mem_req_o = mem_we_o = 1 from the first cycle in WRITE.
  - mem_addr_o = BASE_ADDR + {word_idx, 2'b00}; mem_data_o = assembled word.
  - Request held stable until mem_gnt_i = 1. Grant in the first cycle gives 1-cycle latency from the 4th byte to the write.
  - On grant: word_idx += 1. Go to CSUM if word_idx == count−1, else DATA.
- CSUM:
  - On the byte: match → ok_o = 1; mismatch → err_o = 1, code 10.
  - done_o pulses; halt_o drops the next cycle; go to IDLE.
- Boundaries:
  - Address computed in 32 bits; wraps silently (BASE_ADDR + 4×MAX_WORDS must fit the ROM).
  - rx_valid_i in WRITE is ignored (not accepted) until back in DATA/CSUM.
  - Reset mid-frame → IDLE, halt_o=0, mem_req_o=0 in the following cycle. Partial ROM contents are left as written.

Optional Feature:
- Macro: PROG_LOADER_TIMEOUT_EN.
- Defined:
  - Counter starts at 0 on every accepted byte.
  - It counts in LEN0/LEN1/DATA/CSUM only; it is frozen in WRITE and IDLE.
  - Reaching TIMEOUT_CYCLES → err_o=1, code 11, done_o pulse, halt_o=0, go to IDLE.
- Undefined: no counter logic; the loader waits indefinitely; code 11 is never produced.

Decomposition:
- prog_loader_pkg holds:
  - state enum
  - HDR_BYTE = 8'hA5
  - error code constants ERR_NONE/ERR_LEN/ERR_CSUM/ERR_TMO
- One natural sub-module, prog_loader_word_asm: byte-lane counter plus little-endian 32-bit assembler, with a word_valid strobe and clear input.

Test Plan:
- Reset: drive rst=0 for 2 cycles with rx_valid_i=1, rx_data_i=0xA5 → all outputs 0, no byte accepted; release → IDLE.
- Load 2 words: A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82 (0x13 + 0x6F = 0x82).
  - Writes: 0x00000013 @ BASE_ADDR, then 0x0000006F @ BASE_ADDR+4.
  - ok_o=1, done_o pulses once, halt_o high from the cycle after A5 until the cycle after the checksum.
- Checksum error: same frame with checksum 0x83 → both writes still occur, err_o=1, err_code_o=10, ok_o=0.
- Grant stall: hold mem_gnt_i=0 for 5 cycles during the first write → address/data stable, rx_ready_o=0 throughout, exactly one write issued.
- Length error: A5 01 10 (count 4097) → err_code_o=01, no mem_req_o ever, next A5 is accepted as a new header.
- Timeout (PROG_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100): A5 01 00 then idle for 100 cycles → err_code_o=11, halt_o=0. Without the macro, the same stimulus keeps halt_o=1.
